// File: rtl/core_wb_arb.sv
// core_wb_arb: write-back arbiter feeding the register-file write port.
// Up to NREQ requesters (0=ALU, 1=LSU, 2=MDU) compete each cycle. The
// winner is loaded into a single registered output stage. Writes to x0
// are accepted but leave reg_wen low.
// Build option: define CORE_WB_ARB_RR_EN for round-robin arbitration with
// a 2-bit pointer; otherwise fixed priority ALU > LSU > MDU.
module core_wb_arb #(
    parameter int unsigned NREQ = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][4:0]  req_waddr,
    input  logic [NREQ-1:0][31:0] req_wdata,
    output logic [4:0]            reg_waddr,
    output logic [31:0]           reg_wdata,
    output logic                  reg_wen,
    output logic [1:0]            grant_id
);

    logic       found;
    logic [1:0] winner;
    logic       transfer;

`ifdef CORE_WB_ARB_RR_EN
    logic [1:0] ptr;

    // Round-robin search starting at the pointer, wrapping NREQ-1 -> 0
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_valid[(32'(ptr) + k) % NREQ]) begin
                found  = 1'b1;
                winner = 2'((32'(ptr) + k) % NREQ);
            end
        end
    end

    // Pointer advances past the winner only on an actual transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (32'(winner) == NREQ - 1) ? 2'd0 : winner + 2'd1;
        end
    end
`else
    // Fixed priority: lowest index wins (ALU > LSU > MDU)
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_valid[k]) begin
                found  = 1'b1;
                winner = 2'(k);
            end
        end
    end
`endif

    assign transfer = found & stall_n;

    // One-hot accept to the winner; forced low while stalled or in reset
    always_comb begin
        req_ready = '0;
        if (transfer && rst_n) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Output stage: load on transfer, drop wen when idle, hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wen   <= 1'b0;
            reg_waddr <= '0;
            reg_wdata <= '0;
            grant_id  <= '0;
        end else if (stall_n) begin
            if (found) begin
                reg_waddr <= req_waddr[winner];
                reg_wdata <= req_wdata[winner];
                grant_id  <= winner;
                reg_wen   <= (req_waddr[winner] != 5'd0);
            end else begin
                reg_wen   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/core_wb_arb.md
CORE_WB_ARB -- requirements
Module: core_wb_arb

Interface
REQ-001 SHALL have parameter NREQ, default 3, meaning number of write-back requesters: 0=ALU, 1=LSU, 2=MDU.
REQ-002 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset is asynchronous, active-low.
REQ-004 SHALL have port stall_n, input, 1: 0 = pipeline stall, 1 = work.
REQ-005 SHALL have port req_valid, input, NREQ, per-requester write request.
REQ-006 SHALL have port req_ready, output, NREQ, per-requester accept (combinational).
REQ-007 SHALL have port req_waddr, input, NREQ x 5, per-requester destination register.
REQ-008 SHALL have port req_wdata, input, NREQ x 32, per-requester write data.
REQ-009 SHALL have ports reg_waddr (5), reg_wdata (32) and reg_wen (1), all outputs, driving the register-file write port.
REQ-010 SHALL have port grant_id, output, 2, index of requester last loaded into the output stage.

Function
REQ-011 A transfer SHALL occur on requester i when req_valid[i] and req_ready[i] are both 1 at a rising edge.
REQ-012 req_ready[i] SHALL be 1 only when stall_n=1 and i is the selected winner; at most one req_ready bit SHALL be set per cycle.
REQ-013 The winner SHALL be chosen among valid requesters only; no valid requester means no ready and no transfer.
REQ-014 On a transfer, the output stage SHALL load reg_waddr, reg_wdata and grant_id from the winner, with reg_wen=1 on the next cycle (latency 1).
REQ-015 On a cycle with stall_n=1 and no transfer, reg_wen SHALL go to 0 on the next edge; reg_waddr, reg_wdata and grant_id SHALL hold.
REQ-016 While stall_n=0, the output stage SHALL hold all values, including reg_wen. No transfer SHALL occur, and requesters SHALL hold valid, address and data.
REQ-017 A transfer with waddr=0 SHALL be accepted and consumed, and SHALL leave reg_wen=0 on the next cycle, so x0 is never written.
REQ-018 A requester SHALL NOT be granted twice in a row while another requester has been valid and waiting (round-robin mode only).
REQ-019 Simultaneous requests to the same waddr SHALL be serialized in grant order. The last granted write wins, and no merging SHALL occur.

Reset
REQ-020 While rst_n=0, the block SHALL drive reg_wen=0, reg_waddr=0, reg_wdata=0, grant_id=0 and req_ready=0, with the round-robin pointer at 0.
REQ-021 Reset asserted mid-operation SHALL drop any pending output-stage write immediately, without waiting for a clock edge.
REQ-022 After rst_n deasserts, the first edge SHALL already be able to accept a transfer.

Configuration
REQ-023 With macro CORE_WB_ARB_RR_EN defined, arbitration SHALL be round-robin with a 2-bit pointer:
- Search starts at the pointer and wraps NREQ-1 -> 0.
- After each transfer, pointer = (winner+1) mod NREQ.
- The pointer SHALL hold when there is no transfer or stall_n=0.
REQ-024 Without CORE_WB_ARB_RR_EN, arbitration SHALL be fixed priority ALU > LSU > MDU, and the pointer logic SHALL be absent.

Verification
REQ-025 Reset then single LSU request: req_valid=010, waddr=5, wdata=0xDEADBEEF -> req_ready=010 in that cycle; next cycle reg_wen=1, reg_waddr=5, reg_wdata=0xDEADBEEF, grant_id=1.
REQ-026 RR_EN build, all three valid continuously for 6 cycles with pointer=0 -> grant order 0,1,2,0,1,2. Non-RR build, same stimulus -> ALU granted all 6 cycles.
REQ-027 Stall hold: transfer ALU waddr=3 wdata=0x11, then stall_n=0 for 3 cycles with LSU valid -> reg_wen=1, waddr=3, wdata=0x11 held all 3 cycles, req_ready=000. After stall_n=1 the LSU transfer SHALL occur.
REQ-028 x0 drop: MDU waddr=0, wdata=0xFFFFFFFF -> req_ready[2]=1, next cycle reg_wen=0.
REQ-029 Async reset: pull rst_n low between edges while reg_wen=1 -> reg_wen=0 before the next edge, and all outputs equal their REQ-020 values.
REQ-030 Same address: ALU and LSU both target waddr=7 with data 0xA and 0xB (RR pointer=0) -> writes 0xA then 0xB on consecutive cycles.
